// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Brief    : RV32 immediate decoder feeding a DEPTH-entry output FIFO.
//            Each accepted instruction is decoded combinationally and the
//            sign-extended immediate, format code and illegal flag are
//            queued for a valid/ready consumer.
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [31:0]                  in_inst,
    output logic                         in_ready,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_imm,
    output logic [2:0]                   out_fmt,
    output logic                         out_illegal,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_PTR_W = $clog2(DEPTH);

    localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;

    localparam logic [2:0] c_FMT_R   = 3'd0;
    localparam logic [2:0] c_FMT_I   = 3'd1;
    localparam logic [2:0] c_FMT_S   = 3'd2;
    localparam logic [2:0] c_FMT_B   = 3'd3;
    localparam logic [2:0] c_FMT_U   = 3'd4;
    localparam logic [2:0] c_FMT_J   = 3'd5;
    localparam logic [2:0] c_FMT_ILL = 3'd7;

    logic [XLEN-1:0]    r_imm_mem [DEPTH];
    logic [2:0]         r_fmt_mem [DEPTH];
    logic               r_ill_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic [XLEN-1:0]    w_imm;
    logic [2:0]         w_fmt;
    logic               w_ill;
    logic               w_s;
    logic               w_push;
    logic               w_pop;
    logic               w_valid;

    // Sign source is always inst[31]; each format rebuilds the remaining
    // low bits so the replication count never reaches zero for XLEN=32.
    assign w_s = in_inst[31];

    // Decode the incoming instruction into immediate, format and illegal flag.
    always_comb begin
        w_imm = '0;
        w_fmt = c_FMT_ILL;
        w_ill = 1'b1;
        case (in_inst[6:0])
            c_OP_OPIMM, c_OP_LOAD, c_OP_JALR, c_OP_SYSTEM, c_OP_FENCE: begin
                w_imm = {{(XLEN-11){w_s}}, in_inst[30:20]};
                w_fmt = c_FMT_I;
                w_ill = 1'b0;
            end
            c_OP_STORE: begin
                w_imm = {{(XLEN-11){w_s}}, in_inst[30:25], in_inst[11:7]};
                w_fmt = c_FMT_S;
                w_ill = 1'b0;
            end
            c_OP_BRANCH: begin
                w_imm = {{(XLEN-12){w_s}}, in_inst[7], in_inst[30:25],
                         in_inst[11:8], 1'b0};
                w_fmt = c_FMT_B;
                w_ill = 1'b0;
            end
            c_OP_LUI, c_OP_AUIPC: begin
                w_imm = {{(XLEN-31){w_s}}, in_inst[30:12], 12'b0};
                w_fmt = c_FMT_U;
                w_ill = 1'b0;
            end
            c_OP_JAL: begin
                w_imm = {{(XLEN-20){w_s}}, in_inst[19:12], in_inst[20],
                         in_inst[30:21], 1'b0};
                w_fmt = c_FMT_J;
                w_ill = 1'b0;
            end
            c_OP_OP: begin
                w_imm = '0;
                w_fmt = c_FMT_R;
                w_ill = 1'b0;
            end
            default: begin
                w_imm = '0;
                w_fmt = c_FMT_ILL;
                w_ill = 1'b1;
            end
        endcase
    end

    // Handshakes; a full queue never passes through, so push needs space.
    assign in_ready  = (r_count != c_CNT_W'(DEPTH));
    assign w_valid   = (r_count != '0);
    assign out_valid = w_valid;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = w_valid & out_ready;
    assign count     = r_count;

    // Queue storage; contents are qualified by count so they need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_imm_mem[r_wr_ptr] <= w_imm;
            r_fmt_mem[r_wr_ptr] <= w_fmt;
            r_ill_mem[r_wr_ptr] <= w_ill;
        end
    end

    // Pointer and occupancy bookkeeping; reset beats flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // Present the head entry, or the idle pattern when the queue is empty.
    assign out_imm     = w_valid ? r_imm_mem[r_rd_ptr] : '0;
    assign out_fmt     = w_valid ? r_fmt_mem[r_rd_ptr] : c_FMT_ILL;
    assign out_illegal = w_valid ? r_ill_mem[r_rd_ptr] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_pipe
// Brief    : Directed bench for imm_gen_pipe; a 32-bit and a 64-bit instance
//            share stimulus so each vector checks both sign-extension widths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_inst;
    logic        flush;
    logic        out_ready;

    logic        rdy32, vld32, ill32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic [2:0]  cnt32;
    logic        rdy64, vld64, ill64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic [2:0]  cnt64;

    int n_vec = 0;
    int n_bad = 0;

    imm_gen_pipe #(.XLEN(32), .DEPTH(4)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst),
        .in_ready(rdy32), .flush(flush), .out_valid(vld32),
        .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
        .out_illegal(ill32), .count(cnt32)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(4)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst),
        .in_ready(rdy64), .flush(flush), .out_valid(vld64),
        .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
        .out_illegal(ill64), .count(cnt64)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " out_valid"}, 64'(vld32), 64'd0);
        chk({tag, " count"}, 64'(cnt32), 64'd0);
        chk({tag, " in_ready"}, 64'(rdy32), 64'd1);
        chk({tag, " out_imm"}, 64'(imm32), 64'd0);
        chk({tag, " out_fmt"}, 64'(fmt32), 64'd7);
        chk({tag, " out_illegal"}, 64'(ill32), 64'd0);
    endtask

    task automatic push1(input logic [31:0] inst);
        in_valid = 1'b1;
        in_inst  = inst;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{32'hFE000EE3, 64'hFFFFFFFF_FFFFFFFC, 3'd3, 1'b0}; // beq -4
        vecs[1]  = '{32'h0080006F, 64'h00000000_00000008, 3'd5, 1'b0}; // jal +8
        vecs[2]  = '{32'h123450B7, 64'h00000000_12345000, 3'd4, 1'b0}; // lui
        vecs[3]  = '{32'hFE20AC23, 64'hFFFFFFFF_FFFFFFF8, 3'd2, 1'b0}; // sw -8
        vecs[4]  = '{32'h0000007F, 64'h00000000_00000000, 3'd7, 1'b1}; // illegal
        vecs[5]  = '{32'h800000B7, 64'hFFFFFFFF_80000000, 3'd4, 1'b0}; // lui neg
        vecs[6]  = '{32'hFFF00093, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0}; // addi -1
        vecs[7]  = '{32'h002081B3, 64'h00000000_00000000, 3'd0, 1'b0}; // add
        vecs[8]  = '{32'h7FF02083, 64'h00000000_000007FF, 3'd1, 1'b0}; // lw +2047
        vecs[9]  = '{32'hFFDFF06F, 64'hFFFFFFFF_FFFFFFFC, 3'd5, 1'b0}; // jal -4
        vecs[10] = '{32'h00001017, 64'h00000000_00001000, 3'd4, 1'b0}; // auipc
        vecs[11] = '{32'h00000073, 64'h00000000_00000000, 3'd1, 1'b0}; // ecall
        vecs[12] = '{32'h0FF0000F, 64'h00000000_000000FF, 3'd1, 1'b0}; // fence
        vecs[13] = '{32'h80000067, 64'hFFFFFFFF_FFFFF800, 3'd1, 1'b0}; // jalr -2048
        vecs[14] = '{32'h000000E3, 64'h00000000_00000800, 3'd3, 1'b0}; // branch +2048
        vecs[15] = '{32'h00000000, 64'h00000000_00000000, 3'd7, 1'b1}; // zero word

        rst = 1'b1; in_valid = 1'b0; in_inst = '0; flush = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_idle("reset");

        // Table: push, check head on both widths, pop, check empty.
        for (int i = 0; i < 16; i++) begin
            push1(vecs[i].inst);
            chk($sformatf("v%0d valid", i), 64'(vld32), 64'd1);
            chk($sformatf("v%0d count", i), 64'(cnt32), 64'd1);
            chk($sformatf("v%0d imm32", i), 64'(imm32), 64'(vecs[i].imm[31:0]));
            chk($sformatf("v%0d fmt32", i), 64'(fmt32), 64'(vecs[i].fmt));
            chk($sformatf("v%0d ill32", i), 64'(ill32), 64'(vecs[i].ill));
            chk($sformatf("v%0d imm64", i), imm64, vecs[i].imm);
            chk($sformatf("v%0d fmt64", i), 64'(fmt64), 64'(vecs[i].fmt));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("v%0d drained", i), 64'(vld32), 64'd0);
        end
        chk_idle("post-table");

        // Streaming with out_ready held: one push and one pop per edge.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_inst = vecs[i].inst;
            tick();
            chk($sformatf("stream%0d imm", i), 64'(imm32), 64'(vecs[i].imm[31:0]));
            chk($sformatf("stream%0d fmt", i), 64'(fmt32), 64'(vecs[i].fmt));
            chk($sformatf("stream%0d count", i), 64'(cnt32), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        chk_idle("stream end");

        // Fill past capacity with a stalled consumer; head must hold steady.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            in_inst = {12'(k), 20'h00013};
            tick();
            chk($sformatf("fill%0d count", k), 64'(cnt32), 64'((k > 4) ? 4 : k));
            chk($sformatf("fill%0d in_ready", k), 64'(rdy32), 64'((k >= 4) ? 0 : 1));
            chk($sformatf("fill%0d head", k), 64'(imm32), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("drain%0d head", k), 64'(imm32), 64'(k));
            tick();
        end
        out_ready = 1'b0;
        chk_idle("drain end");

        // Flush with a concurrent push: both queued entries and the push vanish.
        push1(vecs[0].inst);
        push1(vecs[1].inst);
        chk("pre-flush count", 64'(cnt32), 64'd2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_inst  = vecs[2].inst;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_idle("flush");
        tick();
        chk_idle("flush hold");

        // Reset mid-stream with push and pop both active.
        push1(vecs[0].inst);
        push1(vecs[1].inst);
        push1(vecs[2].inst);
        chk("pre-reset count", 64'(cnt32), 64'd3);
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_inst   = vecs[3].inst;
        tick();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk_idle("mid reset");
        chk("mid reset count64", 64'(cnt64), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
